// File: rtl/cfg_regfile_pkg.sv
// cfg_regfile_pkg
// Shared definitions for the SPI configuration register file.
//   state_t       : transaction FSM states (IDLE, CMD, DATA)
//   CMD_WRITE_BIT : command-byte bit that selects write (1) or read (0)
//   CMD_ADDR_W    : width of the start address carried in the command byte
//   ADDR_MAX      : highest encodable address; the burst address saturates here
package cfg_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_ADDR_W    = 7;

    localparam logic [CMD_ADDR_W-1:0] ADDR_MAX = '1;

endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync
// Two-flop synchroniser for an asynchronous input, followed by a registered
// copy used for edge detection in the clk domain.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   din    : asynchronous input
//   sync   : synchronised level
//   rise   : one-cycle pulse when the synchronised level goes 0 -> 1
//   fall   : one-cycle pulse when the synchronised level goes 1 -> 0
// RESET_LEVEL sets the level all stages hold during reset, which decides
// whether the first post-reset sample can look like an edge.
module spi_input_sync #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic stage;
    logic prev;

    // meta/stage form the synchroniser; prev is one cycle older for edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta  <= RESET_LEVEL;
            stage <= RESET_LEVEL;
            prev  <= RESET_LEVEL;
        end else begin
            meta  <= din;
            stage <= meta;
            prev  <= stage;
        end
    end

    assign sync = stage;
    assign rise = stage & ~prev;
    assign fall = ~stage & prev;

endmodule

// File: rtl/spi_cfg_regfile.sv
// spi_cfg_regfile
// SPI (mode 0) addressed, double-buffered configuration register file.
// SPI writes land in shadow registers; dirty shadows are copied into the
// active registers on frame_tick (or right after each write when
// COMMIT_ON_FRAME = 0) so a display never sees a half-updated configuration.
// Ports:
//   clk, rst_n   : system clock, synchronous active-low reset
//   ss           : SPI select, active-low, asynchronous
//   sclk, mosi   : SPI clock and data in (MSB first), asynchronous
//   miso         : SPI data out, 0 whenever ss is high
//   frame_tick   : one-cycle pulse at the start of vertical blanking
//   config_flat  : all active registers, register i at [i*REG_WIDTH +: REG_WIDTH]
//   update       : one-cycle pulse the cycle after a commit
//   busy         : high while a transaction is in progress
module spi_cfg_regfile
    import cfg_regfile_pkg::*;
#(
    parameter int NUM_REGS        = 4,
    parameter int REG_WIDTH       = 32,
    parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUE = {96'h0, 32'hBBFC_0000},
    parameter bit COMMIT_ON_FRAME = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ss,
    input  logic                          sclk,
    input  logic                          mosi,
    output logic                          miso,
    input  logic                          frame_tick,
    output logic [NUM_REGS*REG_WIDTH-1:0] config_flat,
    output logic                          update,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = $clog2(REG_WIDTH);

    localparam logic [CNT_W-1:0]      LAST_CMD_BIT  = CNT_W'(7);
    localparam logic [CNT_W-1:0]      LAST_DATA_BIT = CNT_W'(REG_WIDTH - 1);
    localparam logic [CMD_ADDR_W:0]   REG_COUNT     = (CMD_ADDR_W + 1)'(NUM_REGS);

    function automatic logic in_range(input logic [CMD_ADDR_W-1:0] a);
        return {1'b0, a} < REG_COUNT;
    endfunction

    logic ss_sync;
    logic ss_rise;
    logic ss_fall;
    logic sclk_sync;
    logic sclk_rise;
    logic sclk_fall;
    logic mosi_meta;
    logic mosi_sync;

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [REG_WIDTH-1:0]    shift_in;
    logic [REG_WIDTH-1:0]    tx;
    logic [CMD_ADDR_W-1:0]   addr;
    logic                    is_write;
    logic [NUM_REGS-1:0]     dirty;
    logic                    commit_done;
    logic [REG_WIDTH-1:0]    active [NUM_REGS];
    logic [REG_WIDTH-1:0]    shadow [NUM_REGS];

    logic [7:0]              cmd_byte;
    logic [REG_WIDTH-1:0]    word_in;
    logic [CMD_ADDR_W-1:0]   addr_next;
    logic [CMD_ADDR_W-1:0]   rd_addr;
    logic [REG_WIDTH-1:0]    rd_word;
    logic                    commit;

    // The select synchroniser resets low so that a select already held low
    // through reset never looks like a fresh falling edge; a transaction cut
    // by reset is only restarted after ss rises and falls again.
    spi_input_sync #(.RESET_LEVEL(1'b0)) u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ss),
        .sync  (ss_sync),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_input_sync #(.RESET_LEVEL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .sync  (sclk_sync),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, ss_rise, sclk_sync};

    // mosi needs the same two-stage delay as sclk so the bit is aligned with
    // the detected rising edge, but no edge detection of its own
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    // Words completed on this rising edge, the next burst address, and the
    // word the TX shifter should load for a read (command end or boundary)
    always_comb begin
        cmd_byte  = {shift_in[6:0], mosi_sync};
        word_in   = {shift_in[REG_WIDTH-2:0], mosi_sync};
        addr_next = (addr == ADDR_MAX) ? addr : addr + 1'b1;
        rd_addr   = (state == CMD) ? cmd_byte[CMD_ADDR_W-1:0] : addr_next;
        rd_word   = '0;
        if (in_range(rd_addr)) begin
            rd_word = active[rd_addr[IDX_W-1:0]];
        end
        commit = COMMIT_ON_FRAME ? (frame_tick && (|dirty)) : (|dirty);
    end

    // Transaction FSM, shift registers, shadow/dirty bookkeeping and commit.
    // The commit loop runs first so that a shadow write on the same cycle
    // re-marks its register dirty and keeps the new word for the next commit,
    // while the active copy takes the older shadow value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_in    <= '0;
            tx          <= '0;
            addr        <= '0;
            is_write    <= 1'b0;
            dirty       <= '0;
            commit_done <= 1'b0;
            update      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                active[i] <= RESET_VALUE[i*REG_WIDTH +: REG_WIDTH];
                shadow[i] <= RESET_VALUE[i*REG_WIDTH +: REG_WIDTH];
            end
        end else begin
            commit_done <= commit;
            update      <= commit_done;

            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit && dirty[i]) begin
                    active[i] <= shadow[i];
                    dirty[i]  <= 1'b0;
                end
            end

            if (ss_sync) begin
                state   <= IDLE;
                bit_cnt <= '0;
                tx      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ss_fall) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                            tx      <= '0;
                        end
                    end

                    CMD: begin
                        if (sclk_rise) begin
                            shift_in <= word_in;
                            if (bit_cnt == LAST_CMD_BIT) begin
                                state    <= DATA;
                                bit_cnt  <= '0;
                                is_write <= cmd_byte[CMD_WRITE_BIT];
                                addr     <= cmd_byte[CMD_ADDR_W-1:0];
                                tx       <= cmd_byte[CMD_WRITE_BIT] ? '0 : rd_word;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    DATA: begin
                        if (sclk_rise) begin
                            shift_in <= word_in;
                            if (bit_cnt == LAST_DATA_BIT) begin
                                bit_cnt <= '0;
                                addr    <= addr_next;
                                if (is_write) begin
                                    if (in_range(addr)) begin
                                        shadow[addr[IDX_W-1:0]] <= word_in;
                                        dirty[addr[IDX_W-1:0]]  <= 1'b1;
                                    end
                                end else begin
                                    tx <= rd_word;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else if (sclk_fall && (bit_cnt != '0)) begin
                            // The falling edge right after a load is skipped so
                            // the freshly loaded MSB stays up for the master's
                            // first sampling edge of the word.
                            tx <= {tx[REG_WIDTH-2:0], 1'b0};
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign config_flat[g*REG_WIDTH +: REG_WIDTH] = active[g];
        end
    endgenerate

    assign miso = (state == DATA) && !ss && tx[REG_WIDTH-1];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// tb_spi_cfg_regfile
// Drives two register files over SPI: dut_a commits on frame_tick, dut_b
// commits immediately. sclk, mosi, frame_tick and rst_n are shared; each DUT
// has its own select line. Read data is checked against a queue of expected
// words pushed when the read command is issued.
module tb_spi_cfg_regfile;

    localparam int NR = 4;
    localparam int RW = 32;
    localparam logic [NR*RW-1:0] RV = {96'h0, 32'hBBFC_0000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ss_a = 1'b1;
    logic ss_b = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic frame_tick = 1'b0;

    logic miso_a, miso_b, update_a, update_b, busy_a, busy_b;
    logic [NR*RW-1:0] cfg_a, cfg_b;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_act[NR];
    logic [31:0] m_shd[NR];
    logic [NR-1:0] m_dirty;
    logic [31:0] m_b[NR];
    logic [31:0] txw[4];

    int imm_idx;
    logic [31:0] imm_old;
    logic [31:0] imm_new;

    always #5 clk = ~clk;

    spi_cfg_regfile #(
        .NUM_REGS(NR), .REG_WIDTH(RW), .RESET_VALUE(RV), .COMMIT_ON_FRAME(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .ss(ss_a), .sclk(sclk), .mosi(mosi),
        .miso(miso_a), .frame_tick(frame_tick), .config_flat(cfg_a),
        .update(update_a), .busy(busy_a)
    );

    spi_cfg_regfile #(
        .NUM_REGS(NR), .REG_WIDTH(RW), .RESET_VALUE(RV), .COMMIT_ON_FRAME(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ss(ss_b), .sclk(sclk), .mosi(mosi),
        .miso(miso_b), .frame_tick(frame_tick), .config_flat(cfg_b),
        .update(update_b), .busy(busy_b)
    );

    function automatic logic [31:0] reg_a(input int i);
        return cfg_a[i*RW +: RW];
    endfunction

    function automatic logic [31:0] reg_b(input int i);
        return cfg_b[i*RW +: RW];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int a, input logic [31:0] w);
        if (a < NR) begin
            m_shd[a]   = w;
            m_dirty[a] = 1'b1;
        end
    endtask

    task automatic model_tick();
        for (int i = 0; i < NR; i++) begin
            if (m_dirty[i]) m_act[i] = m_shd[i];
        end
        m_dirty = '0;
    endtask

    task automatic check_all_a(input string tag);
        for (int i = 0; i < NR; i++) begin
            checkOutput($sformatf("%s_reg%0d", tag, i), reg_a(i), m_act[i]);
        end
    endtask

    // One SPI mode-0 shift of nbits, MSB first. miso is sampled just before
    // each rising edge. On the final bit, mode 1 pulses frame_tick on the
    // clk cycle where the DUT acts on that edge; mode 2 checks immediate
    // commit timing on dut_b around that edge.
    task automatic spi_xfer(input bit tgt, input logic [31:0] data, input int nbits,
                            input int mode, output logic [31:0] rx);
        rx = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = data[i];
            #50;
            rx = {rx[30:0], (tgt ? miso_b : miso_a)};
            sclk = 1'b1;
            if (i == 0 && mode == 1) begin
                #20 frame_tick = 1'b1;
                #10 frame_tick = 1'b0;
                #20;
            end else if (i == 0 && mode == 2) begin
                #30 checkOutput("imm_before_commit", reg_b(imm_idx), imm_old);
                #10 checkOutput("imm_commit", reg_b(imm_idx), imm_new);
                checkOutput("imm_update_lo", update_b, 1'b0);
                #10 checkOutput("imm_update_hi", update_b, 1'b1);
            end else begin
                #50;
            end
            sclk = 1'b0;
        end
    endtask

    // Full transaction: command byte, nwords words from txw[], then an
    // optional partial word of last_bits bits before ss is raised.
    task automatic applyStimulus(input bit tgt, input logic [7:0] cmd, input int nwords,
                                 input int last_bits, input int mode);
        logic [31:0] rx;
        logic [31:0] exp;
        int a;
        a = int'(cmd[6:0]);
        if (!cmd[7]) begin
            for (int k = 0; k < nwords; k++) begin
                exp_q.push_back((a + k < NR) ? m_act[a + k] : 32'h0);
            end
        end
        if (tgt) ss_b = 1'b0; else ss_a = 1'b0;
        #100;
        checkOutput("busy_in_txn", tgt ? busy_b : busy_a, 1'b1);
        spi_xfer(tgt, {24'h0, cmd}, 8, 0, rx);
        for (int k = 0; k < nwords; k++) begin
            spi_xfer(tgt, txw[k], 32, (k == nwords - 1 && last_bits == 0) ? mode : 0, rx);
            if (!cmd[7]) begin
                exp = exp_q.pop_front();
                checkOutput($sformatf("read_a%0d", a + k), rx, exp);
            end else if (tgt) begin
                if (a + k < NR) m_b[a + k] = txw[k];
            end else begin
                if (mode == 1 && k == nwords - 1) model_tick();
                model_write(a + k, txw[k]);
            end
        end
        if (last_bits > 0) begin
            spi_xfer(tgt, txw[nwords] >> (32 - last_bits), last_bits, 0, rx);
        end
        #50;
        if (tgt) ss_b = 1'b1; else ss_a = 1'b1;
        #200;
        checkOutput("busy_after_txn", tgt ? busy_b : busy_a, 1'b0);
        checkOutput("miso_idle", tgt ? miso_b : miso_a, 1'b0);
    endtask

    // frame_tick pulse on dut_a: registers at tick+1, update at tick+2 only
    // when something was dirty
    task automatic frame_pulse(input string tag);
        logic had_dirty;
        had_dirty = |m_dirty;
        frame_tick = 1'b1;
        #10 frame_tick = 1'b0;
        model_tick();
        check_all_a(tag);
        checkOutput({tag, "_upd_t1"}, update_a, 1'b0);
        #10 checkOutput({tag, "_upd_t2"}, update_a, had_dirty);
        #10 checkOutput({tag, "_upd_t3"}, update_a, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_act[i] = RV[i*RW +: RW];
            m_shd[i] = RV[i*RW +: RW];
            m_b[i]   = RV[i*RW +: RW];
        end
        m_dirty = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        checkOutput("rst_reg0", reg_a(0), 32'hBBFC_0000);
        check_all_a("rst");
        checkOutput("rst_b_reg0", reg_b(0), 32'hBBFC_0000);
        checkOutput("rst_miso", miso_a, 1'b0);
        checkOutput("rst_update", update_a, 1'b0);
        checkOutput("rst_busy", busy_a, 1'b0);

        // readback of reset image and out-of-range read
        txw[0] = 32'hFFFF_FFFF;
        applyStimulus(1'b0, 8'h00, 1, 0, 0);
        applyStimulus(1'b0, 8'h7F, 1, 0, 0);

        // single write, held in shadow until frame_tick
        txw[0] = 32'h1234_5678;
        applyStimulus(1'b0, 8'h81, 1, 0, 0);
        checkOutput("single_pre_tick_reg1", reg_a(1), 32'h0);
        frame_pulse("single");
        checkOutput("single_reg1", reg_a(1), 32'h1234_5678);
        applyStimulus(1'b0, 8'h01, 1, 0, 0);

        // burst of three words from reg2: third word falls off the end
        txw[0] = 32'hA5A5_0001;
        txw[1] = 32'h0B0B_0002;
        txw[2] = 32'hCCCC_0003;
        applyStimulus(1'b0, 8'h82, 3, 0, 0);
        frame_pulse("burst");
        checkOutput("burst_reg2", reg_a(2), 32'hA5A5_0001);
        checkOutput("burst_reg3", reg_a(3), 32'h0B0B_0002);
        applyStimulus(1'b0, 8'h02, 2, 0, 0);

        // abort after 20 data bits: nothing becomes dirty
        txw[0] = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 8'h80, 0, 20, 0);
        frame_pulse("abort");
        checkOutput("abort_reg0", reg_a(0), 32'hBBFC_0000);

        // boundary on the same cycle as frame_tick while reg0 already dirty
        txw[0] = 32'h1111_2222;
        applyStimulus(1'b0, 8'h80, 1, 0, 0);
        txw[0] = 32'h3333_4444;
        applyStimulus(1'b0, 8'h80, 1, 0, 1);
        check_all_a("collide");
        checkOutput("collide_reg0_old", reg_a(0), 32'h1111_2222);
        frame_pulse("collide_next");
        checkOutput("collide_reg0_new", reg_a(0), 32'h3333_4444);

        // immediate-commit instance, no frame_tick involved
        imm_idx = 1;
        imm_old = m_b[1];
        imm_new = 32'hCAFE_F00D;
        txw[0]  = imm_new;
        applyStimulus(1'b1, 8'h81, 1, 0, 2);
        for (int i = 0; i < NR; i++) begin
            checkOutput($sformatf("imm_reg%0d", i), reg_b(i), m_b[i]);
        end

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
